layer0_patch_fetch: RTL
=======================

# layer0_patch_fetch

Upstream feeder for `layer0_engine`. It takes one output-pixel coordinate per request and reads the 3×3×3 input window from the image memory, applying zero padding. The 27 activations are held in a patch buffer that the engine reads combinationally through its `mac_index`. Each request yields exactly one patch, which stays available until the engine releases it.

## Interface
- `IMG_W`, 416, input image width in pixels
- `IMG_H`, 416, input image height in pixels
- `STRIDE`, 2, convolution stride
- `PAD`, 1, zero padding on every side
- `COORD_W`, 9, width of output coordinates
- `ADDR_W`, 20, image memory address width (CHW layout: `c*IMG_H*IMG_W + y*IMG_W + x`)
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  1  coordinate request valid
- `req_ready`  out  1  block can accept a request this cycle
- `req_ox`, `req_oy`  in  COORD_W  output pixel coordinate
- `mem_rd_en`  out  1  image memory read strobe
- `mem_addr`  out  ADDR_W  read address
- `mem_rd_data`  in  8  signed pixel; valid in the cycle after the `mem_rd_en` cycle (1-cycle latency)
- `patch_valid`  out  1  a complete patch is presented
- `patch_ox`, `patch_oy`  out  COORD_W  coordinate of the presented patch
- `mac_index`  in  5  tap select from the engine
- `act_out`  out  8  signed `patch[mac_index]`, combinational; 0 when `mac_index` > 26
- `patch_done`  in  1  engine finished with the presented patch; 1-cycle pulse

## Operation
- Tap order is `k = c*9 + ky*3 + kx`, with c, ky, kx each in 0..2. This order is identical to the engine's weight order.
- Input coordinates per tap:
  - `iy = oy*STRIDE + ky - PAD`
  - `ix = ox*STRIDE + kx - PAD`
  - Both are computed signed, at least COORD_W+3 bits wide.
- A tap is padding when `iy < 0`, `iy >= IMG_H`, `ix < 0` or `ix >= IMG_W`. For a padding tap, no read is issued and 0 is written to the buffer.
- Requests whose coordinates fall far out of range are legal. Every tap becomes padding.
- FSM states:
  - IDLE: `req_ready` = a free bank exists. `req_valid & req_ready` latches the coordinate, zeroes the tap counter and moves to ISSUE.
  - ISSUE: one tap per cycle for 27 cycles. `mem_rd_en` is high only for non-padding taps. A one-stage pipeline carries the tap index and pad flag so each buffer write lines up with the returned data. After tap 26 the FSM moves to DRAIN.
  - DRAIN: one cycle. The last write lands, the bank is marked full and the FSM returns to IDLE.
- Presentation:
  - `patch_valid` = the oldest full bank exists.
  - `patch_done` while `patch_valid` is high frees that bank.
  - `patch_done` while `patch_valid` is low is ignored.
- `act_out` is stable for the whole time `patch_valid` is high.

## Timing
- Reset values: `req_ready` 0 during reset and 1 in the cycle after; `mem_rd_en` 0; `mem_addr` 0; `patch_valid` 0; `patch_ox`/`patch_oy` 0; buffers cleared; FSM in IDLE.
- Fixed latency regardless of padding. With the accepting edge as E0:
  - `mem_rd_en` slots occupy the cycles after E0..E26.
  - The last buffer write happens at E28.
  - `patch_valid` goes high after E28.
- `req_ready` is registered. A request that arrives in the same cycle as `patch_done` is accepted one cycle later.
- `patch_valid` deasserts in the cycle after `patch_done` unless another full bank exists.
- Asserting `rst` mid-fetch aborts it. `mem_rd_en` is 0 in the next cycle and all banks are empty.

## Configuration
- `PATCH_DBUF_EN` defined: two patch banks, served in FIFO order.
  - A new request may be accepted and filled while the other bank is presented.
  - If a fill completes on the same edge as `patch_done`, `patch_valid` stays high and the new bank is presented next cycle.
- `PATCH_DBUF_EN` undefined: one bank. `req_ready` = IDLE and the bank is empty, so fetch and compute never overlap.

## Structure
- Package `layer0_pkg` holds:
  - constants `L0_MACS = 27`, `L0_K = 3`, `L0_CIN = 3`;
  - the FSM state enum;
  - a function decoding k into (c, ky, kx).
- Sub-module `layer0_patch_bank`: 27×int8 storage with one synchronous write port, one combinational read port, and a full flag with set/clear. It is instantiated once, or twice under `PATCH_DBUF_EN`.

## Test plan
Bench setup: IMG_W = IMG_H = 8, memory pre-loaded with `mem[a] = (a+1) & 0xFF`, engine side modelled by the bench.
- Interior request (1,1) → 27 reads; `patch[0] = 10`, `patch[26] = 2*64 + 3*8 + 3 + 1 = 156`; `patch_valid` rises exactly 28 clocks after acceptance.
- Corner request (0,0) → exactly 12 `mem_rd_en` cycles; `patch[0] = 0`, `patch[4] = 1`; latency is still 28.
- Bottom edge request (3,4) → taps with ky ≥ 1 read 0, so `patch[26] = 0` and `patch[9] = 64 + 7*8 + 5 + 1 = 126`; `act_out` = 0 for `mac_index = 31`.
- Hold: `patch_done` withheld for 100 cycles → `patch_valid`, `patch_ox`/`patch_oy` and every `act_out` stay stable; `req_ready` = 0 (single bank).
- Back-to-back under `PATCH_DBUF_EN`: requests (1,1) then (2,2) → the second fill overlaps; the second patch is presented the cycle after the first `patch_done`; without the macro the second acceptance waits for that `patch_done`.
- `rst` asserted at tap 10 → `mem_rd_en` 0 the next cycle, `patch_valid` never rises; a fresh request then completes normally.

Source files
------------

// File: rtl/layer0_pkg.sv
//------------------------------------------------------------------------------
// Module   : layer0_pkg
// Purpose  : Shared constants, FSM state type and tap decoder for layer0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package layer0_pkg;

    localparam int L0_MACS = 27;
    localparam int L0_K    = 3;
    localparam int L0_CIN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] ky;
        logic [1:0] kx;
    } tap_pos_t;

    // k = c*9 + ky*3 + kx, the same order the engine stores its weights in
    function automatic tap_pos_t tap_decode(input logic [4:0] k);
        tap_pos_t p;
        p.c  = 2'(k / 5'd9);
        p.ky = 2'((k % 5'd9) / 5'd3);
        p.kx = 2'(k % 5'd3);
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/layer0_patch_bank.sv
//------------------------------------------------------------------------------
// Module   : layer0_patch_bank
// Purpose  : 27 x int8 patch store, sync write, comb read, full flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module layer0_patch_bank
    import layer0_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [4:0]        wr_idx,
    input  logic signed [7:0] wr_data,
    input  logic [4:0]        rd_idx,
    output logic signed [7:0] rd_data,
    input  logic              set_full,
    input  logic              clr_full,
    output logic              full
);

    logic signed [7:0] r_mem [0:L0_MACS-1];
    logic              r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L0_MACS; i++) begin
                r_mem[i] <= '0;
            end
            r_full <= 1'b0;
        end else begin
            if (wr_en && (wr_idx < 5'(L0_MACS))) begin
                r_mem[wr_idx] <= wr_data;
            end
            if (set_full) begin
                r_full <= 1'b1;
            end else if (clr_full) begin
                r_full <= 1'b0;
            end
        end
    end

    assign rd_data = (rd_idx < 5'(L0_MACS)) ? r_mem[rd_idx] : 8'sd0;
    assign full    = r_full;

endmodule

`default_nettype wire

// File: rtl/layer0_patch_fetch.sv
//------------------------------------------------------------------------------
// Module   : layer0_patch_fetch
// Purpose  : Fetches a zero-padded 3x3x3 input window per output pixel into a
//            patch bank read by layer0_engine. Define PATCH_DBUF_EN for two
//            FIFO-ordered banks (fetch overlaps compute); default is one bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module layer0_patch_fetch
    import layer0_pkg::*;
#(
    parameter int IMG_W   = 416,
    parameter int IMG_H   = 416,
    parameter int STRIDE  = 2,
    parameter int PAD     = 1,
    parameter int COORD_W = 9,
    parameter int ADDR_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COORD_W-1:0]  req_ox,
    input  logic [COORD_W-1:0]  req_oy,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic signed [7:0]   mem_rd_data,
    output logic                patch_valid,
    output logic [COORD_W-1:0]  patch_ox,
    output logic [COORD_W-1:0]  patch_oy,
    input  logic [4:0]          mac_index,
    output logic signed [7:0]   act_out,
    input  logic                patch_done
);

`ifdef PATCH_DBUF_EN
    localparam int c_NBANK = 2;
`else
    localparam int c_NBANK = 1;
`endif
    localparam int         c_CW       = COORD_W + 3;
    localparam logic [4:0] c_LAST_TAP = 5'(L0_MACS - 1);

    fetch_state_t        r_state, w_state_next;
    logic [4:0]          r_tap;
    logic [COORD_W-1:0]  r_ox, r_oy;
    logic                r_pipe_vld, r_pipe_pad;
    logic [4:0]          r_pipe_tap;
    logic                r_wr_ptr, r_rd_ptr;
    logic                r_req_ready;
    logic [COORD_W-1:0]  r_bank_ox [0:1];
    logic [COORD_W-1:0]  r_bank_oy [0:1];

    logic [1:0]          w_full, w_full_next;
    logic signed [7:0]   w_rd_data [0:1];
    tap_pos_t            w_tap;
    logic signed [c_CW-1:0] w_iy, w_ix;
    logic                w_pad, w_accept, w_fill_done, w_release;
    logic                w_wr_ptr_next, w_rd_ptr_next, w_ready_next;
    logic signed [7:0]   w_wr_data;

    assign w_tap = tap_decode(r_tap);
    assign w_iy  = $signed({3'b000, r_oy}) * $signed(c_CW'(STRIDE))
                 + $signed(c_CW'(w_tap.ky)) - $signed(c_CW'(PAD));
    assign w_ix  = $signed({3'b000, r_ox}) * $signed(c_CW'(STRIDE))
                 + $signed(c_CW'(w_tap.kx)) - $signed(c_CW'(PAD));
    assign w_pad = w_iy[c_CW-1] || (w_iy >= $signed(c_CW'(IMG_H)))
                || w_ix[c_CW-1] || (w_ix >= $signed(c_CW'(IMG_W)));

    assign mem_rd_en = (r_state == ST_ISSUE) && !w_pad;
    assign mem_addr  = mem_rd_en ?
                       (ADDR_W'(w_tap.c) * ADDR_W'(IMG_H * IMG_W)
                      + ADDR_W'($unsigned(w_iy)) * ADDR_W'(IMG_W)
                      + ADDR_W'($unsigned(w_ix))) : '0;

    assign w_accept    = (r_state == ST_IDLE) && req_valid && r_req_ready;
    assign w_fill_done = (r_state == ST_DRAIN);
    assign patch_valid = w_full[r_rd_ptr];
    assign w_release   = patch_done && patch_valid;
    assign w_wr_data   = r_pipe_pad ? 8'sd0 : mem_rd_data;

    assign w_wr_ptr_next = (w_fill_done && (c_NBANK == 2)) ? ~r_wr_ptr : r_wr_ptr;
    assign w_rd_ptr_next = (w_release   && (c_NBANK == 2)) ? ~r_rd_ptr : r_rd_ptr;
    // Registered ready: look ahead at the state and bank occupancy after this edge
    assign w_ready_next  = (w_state_next == ST_IDLE) && !w_full_next[w_wr_ptr_next];

    assign req_ready = r_req_ready;
    assign patch_ox  = r_bank_ox[r_rd_ptr];
    assign patch_oy  = r_bank_oy[r_rd_ptr];
    assign act_out   = w_rd_data[r_rd_ptr];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
            ST_ISSUE: if (r_tap == c_LAST_TAP) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tap        <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_pipe_vld   <= 1'b0;
            r_pipe_pad   <= 1'b0;
            r_pipe_tap   <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_req_ready  <= 1'b0;
            r_bank_ox[0] <= '0;
            r_bank_ox[1] <= '0;
            r_bank_oy[0] <= '0;
            r_bank_oy[1] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= w_ready_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            // One-stage pipe aligns each buffer write with the returning read data
            r_pipe_vld  <= (r_state == ST_ISSUE);
            r_pipe_pad  <= w_pad;
            r_pipe_tap  <= r_tap;
            if (w_accept) begin
                r_ox                <= req_ox;
                r_oy                <= req_oy;
                r_tap               <= '0;
                r_bank_ox[r_wr_ptr] <= req_ox;
                r_bank_oy[r_wr_ptr] <= req_oy;
            end else if (r_state == ST_ISSUE) begin
                r_tap <= r_tap + 5'd1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < c_NBANK) begin : g_used
            logic w_sel_wr, w_sel_rd;
            assign w_sel_wr       = (r_wr_ptr == 1'(b));
            assign w_sel_rd       = (r_rd_ptr == 1'(b));
            assign w_full_next[b] = (w_fill_done && w_sel_wr)
                                 || (w_full[b] && !(w_release && w_sel_rd));

            layer0_patch_bank u_bank (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (r_pipe_vld && w_sel_wr),
                .wr_idx   (r_pipe_tap),
                .wr_data  (w_wr_data),
                .rd_idx   (mac_index),
                .rd_data  (w_rd_data[b]),
                .set_full (w_fill_done && w_sel_wr),
                .clr_full (w_release && w_sel_rd),
                .full     (w_full[b])
            );
        end else begin : g_unused
            assign w_full[b]      = 1'b0;
            assign w_full_next[b] = 1'b0;
            assign w_rd_data[b]   = 8'sd0;
        end
    end

endmodule

`default_nettype wire
